// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: single data-memory port shared by store drain and load path, store priority with bounded load starvation
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             st_req,
  input  logic [31:0]      st_addr,
  input  logic [3:0]       st_wmask,
  input  logic [31:0]      st_wdata,
  output logic             st_gnt,
  output logic             st_done,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_rmask,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_gnt,
  output logic             ld_resp,
  output logic [31:0]      ld_rdata,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic             busy,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [1:0] state;
  logic [CW-1:0] starve_cnt;
  logic drop;
  logic [TAG_W-1:0] tag_q;
  logic ld_elig, st_win, ld_win, resp_ok;
  always_comb begin
    ld_elig = ld_req && !flush;
    st_win = state == IDLE && st_req && (!ld_elig || starve_cnt < LIM);
    ld_win = state == IDLE && !st_win && ld_elig;
    resp_ok = state == LOAD && dmem_resp && !drop && !flush;
    st_gnt = st_win;
    ld_gnt = ld_win;
    st_done = state == STORE && dmem_resp;
    ld_resp = resp_ok;
    ld_rdata = resp_ok ? dmem_rdata : 32'd0;
    ld_resp_tag = resp_ok ? tag_q : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      drop <= 1'b0;
      tag_q <= '0;
      dmem_addr <= 32'd0;
      dmem_rmask <= 4'd0;
      dmem_wmask <= 4'd0;
      dmem_wdata <= 32'd0;
    end else begin
      starve_cnt <= (!ld_req || ld_win) ? '0 : (st_win && starve_cnt < LIM) ? starve_cnt + 1'b1 : starve_cnt;
      if (st_win) begin
        state <= STORE;
        dmem_addr <= st_addr;
        dmem_rmask <= 4'd0;
        dmem_wmask <= st_wmask;
        dmem_wdata <= st_wdata;
      end else if (ld_win) begin
        state <= LOAD;
        tag_q <= ld_tag;
        dmem_addr <= ld_addr;
        dmem_rmask <= ld_rmask;
        dmem_wmask <= 4'd0;
        dmem_wdata <= 32'd0;
      end else if (state != IDLE && dmem_resp) begin
        state <= IDLE;
        dmem_rmask <= 4'd0;
        dmem_wmask <= 4'd0;
      end
      drop <= state == LOAD && !dmem_resp && (drop || flush);
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  logic clk = 0, rst = 1, flush = 0;
  logic st_req = 0, ld_req = 0, dmem_resp = 0;
  logic [31:0] st_addr = 0, st_wdata = 0, ld_addr = 0, dmem_rdata = 0;
  logic [3:0] st_wmask = 0, ld_rmask = 0;
  logic [4:0] ld_tag = 0;
  logic st_gnt, st_done, ld_gnt, ld_resp, busy;
  logic [31:0] ld_rdata, dmem_addr, dmem_wdata;
  logic [4:0] ld_resp_tag;
  logic [3:0] dmem_rmask, dmem_wmask;
  int checks = 0, fails = 0;

  dmem_port_arbiter #(.STARVE_LIMIT(4), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .st_req(st_req), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata),
    .st_gnt(st_gnt), .st_done(st_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_tag(ld_tag),
    .ld_gnt(ld_gnt), .ld_resp(ld_resp), .ld_rdata(ld_rdata), .ld_resp_tag(ld_resp_tag),
    .busy(busy), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    dmem_rdata = 32'hA5A5_A5A5;
    ld_tag = 5'd17;
    #1;
    checks++; if ({st_gnt, st_done, ld_gnt, ld_resp, busy} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b want 00000", {st_gnt, st_done, ld_gnt, ld_resp, busy}); end
    checks++; if ({dmem_addr, dmem_wdata, dmem_rmask, dmem_wmask} !== 72'd0) begin fails++; $display("FAIL reset_dmem got %h want 0", {dmem_addr, dmem_wdata, dmem_rmask, dmem_wmask}); end
    checks++; if ({ld_rdata, ld_resp_tag} !== 37'd0) begin fails++; $display("FAIL reset_ld_data got %h want 0", {ld_rdata, ld_resp_tag}); end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_single_load();
    ld_req = 1; ld_addr = 32'h1000_0004; ld_rmask = 4'hF; ld_tag = 5'd3;
    #1;
    checks++; if (ld_gnt !== 1'b1 || st_gnt !== 1'b0) begin fails++; $display("FAIL load_gnt got ld=%b st=%b want 1 0", ld_gnt, st_gnt); end
    tick();
    ld_req = 0; ld_addr = 0; ld_rmask = 0; ld_tag = 0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++; if (dmem_rmask !== 4'hF || dmem_wmask !== 4'h0 || dmem_addr !== 32'h1000_0004 || ld_resp !== 1'b0) begin fails++; $display("FAIL load_hold c%0d got rmask=%h wmask=%h addr=%h resp=%b", c, dmem_rmask, dmem_wmask, dmem_addr, ld_resp); end
      tick();
    end
    dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (ld_resp !== 1'b1 || ld_rdata !== 32'hDEAD_BEEF || ld_resp_tag !== 5'd3 || dmem_rmask !== 4'hF) begin fails++; $display("FAIL load_resp got resp=%b data=%h tag=%0d rmask=%h want 1 deadbeef 3 f", ld_resp, ld_rdata, ld_resp_tag, dmem_rmask); end
    checks++; if (ld_gnt !== 1'b0) begin fails++; $display("FAIL load_resp_no_gnt got %b want 0", ld_gnt); end
    tick();
    dmem_resp = 0;
    #1;
    checks++; if (dmem_rmask !== 4'h0 || busy !== 1'b0 || dmem_addr !== 32'h1000_0004) begin fails++; $display("FAIL load_idle got rmask=%h busy=%b addr=%h", dmem_rmask, busy, dmem_addr); end
    tick();
  endtask

  task automatic test_contention();
    st_req = 1; st_addr = 32'h2000; st_wmask = 4'h3; st_wdata = 32'h0000_1234;
    ld_req = 1; ld_addr = 32'h3000; ld_rmask = 4'hC; ld_tag = 5'd5;
    #1;
    checks++; if (st_gnt !== 1'b1 || ld_gnt !== 1'b0) begin fails++; $display("FAIL cont_first got st=%b ld=%b want 1 0", st_gnt, ld_gnt); end
    tick();
    st_req = 0;
    #1;
    checks++; if (dmem_addr !== 32'h2000 || dmem_wmask !== 4'h3 || dmem_rmask !== 4'h0 || dmem_wdata !== 32'h1234 || busy !== 1'b1) begin fails++; $display("FAIL cont_store_bus got addr=%h wm=%h rm=%h wd=%h busy=%b", dmem_addr, dmem_wmask, dmem_rmask, dmem_wdata, busy); end
    dmem_resp = 1;
    #1;
    checks++; if (st_done !== 1'b1 || ld_gnt !== 1'b0 || ld_resp !== 1'b0) begin fails++; $display("FAIL cont_st_done got done=%b ldgnt=%b ldresp=%b want 1 0 0", st_done, ld_gnt, ld_resp); end
    tick();
    dmem_resp = 0;
    #1;
    checks++; if (ld_gnt !== 1'b1 || st_done !== 1'b0 || dmem_wmask !== 4'h0) begin fails++; $display("FAIL cont_load_gnt got gnt=%b done=%b wm=%h want 1 0 0", ld_gnt, st_done, dmem_wmask); end
    tick();
    ld_req = 0;
    #1;
    checks++; if (dmem_rmask !== 4'hC || dmem_wmask !== 4'h0 || dmem_wdata !== 32'd0 || dmem_addr !== 32'h3000) begin fails++; $display("FAIL cont_load_bus got rm=%h wm=%h wd=%h addr=%h", dmem_rmask, dmem_wmask, dmem_wdata, dmem_addr); end
    dmem_resp = 1; dmem_rdata = 32'h0BAD_F00D;
    #1;
    checks++; if (ld_resp !== 1'b1 || ld_resp_tag !== 5'd5 || ld_rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL cont_load_resp got resp=%b tag=%0d data=%h", ld_resp, ld_resp_tag, ld_rdata); end
    tick();
    dmem_resp = 0;
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_ld;
    exp_ld = 10'b10000_10000;
    st_req = 1; st_addr = 32'h4000; st_wmask = 4'h1; st_wdata = 32'h11;
    ld_req = 1; ld_addr = 32'h5000; ld_rmask = 4'hF; ld_tag = 5'd9;
    for (int g = 0; g < 10; g++) begin
      #1;
      checks++; if (ld_gnt !== exp_ld[g] || st_gnt !== !exp_ld[g]) begin fails++; $display("FAIL starve_g%0d got st=%b ld=%b want ld=%b", g, st_gnt, ld_gnt, exp_ld[g]); end
      tick();
      dmem_resp = 1;
      tick();
      dmem_resp = 0;
    end
    st_req = 0; ld_req = 0;
    tick();
  endtask

  task automatic test_flush();
    ld_req = 1; ld_addr = 32'h6000; ld_rmask = 4'hF; ld_tag = 5'd7;
    #1;
    checks++; if (ld_gnt !== 1'b1) begin fails++; $display("FAIL flush_gnt got %b want 1", ld_gnt); end
    tick();
    ld_req = 0;
    flush = 1;
    tick();
    flush = 0;
    tick();
    tick();
    dmem_resp = 1; dmem_rdata = 32'hCAFE_CAFE;
    #1;
    checks++; if (ld_resp !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL flush_drop got resp=%b busy=%b want 0 1", ld_resp, busy); end
    tick();
    dmem_resp = 0;
    #1;
    checks++; if (busy !== 1'b0 || dmem_rmask !== 4'h0) begin fails++; $display("FAIL flush_idle got busy=%b rm=%h want 0 0", busy, dmem_rmask); end
    ld_req = 1; ld_tag = 5'd9; ld_addr = 32'h6004;
    #1;
    checks++; if (ld_gnt !== 1'b1) begin fails++; $display("FAIL flush_next_gnt got %b want 1", ld_gnt); end
    tick();
    ld_req = 0;
    dmem_resp = 1; dmem_rdata = 32'h1234_5678;
    #1;
    checks++; if (ld_resp !== 1'b1 || ld_resp_tag !== 5'd9 || ld_rdata !== 32'h1234_5678) begin fails++; $display("FAIL flush_next_resp got resp=%b tag=%0d data=%h", ld_resp, ld_resp_tag, ld_rdata); end
    tick();
    dmem_resp = 0;
    ld_req = 1; ld_tag = 5'd2;
    #1;
    checks++; if (ld_gnt !== 1'b1) begin fails++; $display("FAIL flush_same_gnt got %b want 1", ld_gnt); end
    tick();
    ld_req = 0;
    dmem_resp = 1; flush = 1;
    #1;
    checks++; if (ld_resp !== 1'b0) begin fails++; $display("FAIL flush_same_resp got %b want 0", ld_resp); end
    tick();
    dmem_resp = 0;
    ld_req = 1; st_req = 1; st_wmask = 4'h8; st_addr = 32'h7000;
    #1;
    checks++; if (ld_gnt !== 1'b0 || st_gnt !== 1'b1) begin fails++; $display("FAIL flush_idle_sel got ld=%b st=%b want 0 1", ld_gnt, st_gnt); end
    st_req = 0;
    #1;
    checks++; if (ld_gnt !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL flush_idle_noload got ld=%b busy=%b want 0 0", ld_gnt, busy); end
    tick();
    flush = 0; ld_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    st_req = 1; st_addr = 32'h8000; st_wmask = 4'hF; st_wdata = 32'h5555_AAAA;
    #1;
    checks++; if (st_gnt !== 1'b1) begin fails++; $display("FAIL rst_store_gnt got %b want 1", st_gnt); end
    tick();
    st_req = 0;
    #1;
    checks++; if (dmem_wmask !== 4'hF || busy !== 1'b1) begin fails++; $display("FAIL rst_store_bus got wm=%h busy=%b want f 1", dmem_wmask, busy); end
    #1 rst = 1;
    #1;
    checks++; if ({dmem_addr, dmem_wdata, dmem_rmask, dmem_wmask} !== 72'd0 || {st_gnt, st_done, ld_gnt, ld_resp, busy} !== 5'b0) begin fails++; $display("FAIL rst_async got dmem=%h flags=%b want 0", {dmem_addr, dmem_wdata, dmem_rmask, dmem_wmask}, {st_gnt, st_done, ld_gnt, ld_resp, busy}); end
    tick();
    rst = 0;
    tick();
    dmem_resp = 1;
    #1;
    checks++; if (st_done !== 1'b0 || ld_resp !== 1'b0) begin fails++; $display("FAIL rst_late_resp got done=%b resp=%b want 0 0", st_done, ld_resp); end
    tick();
    dmem_resp = 0;
    tick();
  endtask

  task automatic test_spurious();
    dmem_resp = 1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (st_done !== 1'b0 || ld_resp !== 1'b0 || ld_rdata !== 32'd0) begin fails++; $display("FAIL spur_resp got done=%b resp=%b data=%h want 0 0 0", st_done, ld_resp, ld_rdata); end
    tick();
    dmem_resp = 0;
    #1;
    checks++; if (busy !== 1'b0 || dmem_rmask !== 4'h0 || dmem_wmask !== 4'h0) begin fails++; $display("FAIL spur_state got busy=%b rm=%h wm=%h want 0 0 0", busy, dmem_rmask, dmem_wmask); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_starvation();
    test_flush();
    test_reset_mid_store();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
